// File: rtl/fsm_core_scheduler.sv
// Round-robin scheduler sharing one 2-bit-input Moore FSM core between four requesters.
// Each grant pulses the core's reset, streams the winner's symbols and returns tagged responses.
module fsm_core_scheduler #(
    parameter logic [3:0] BURST_MAX = 4'd8,
    parameter logic [1:0] IDLE_SYM  = 2'b00
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Req,
    input  logic [7:0] Sym,
    output logic [3:0] Gnt,
    output logic [3:0] Ack,
    output logic       Resp_Valid,
    output logic       Resp,
    output logic [1:0] Resp_Id,
    output logic       Busy,
    output logic [1:0] Core_Data_In,
    output logic       Core_Reset,
    input  logic       Core_Data_Out,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] win_q, win_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       core_rst_q, core_rst_d;
    logic       ack_dly_q, ack_dly_d;
    logic [1:0] id_dly_q, id_dly_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_q, resp_d;
    logic [1:0] resp_id_q, resp_id_d;

    logic       arb_found;
    logic [1:0] arb_idx;
    logic [1:0] arb_probe;
    logic       req_w;
    logic [1:0] sym_w;
    logic       consume;
    logic       burst_done;

    // First requesting index at or after the rr pointer, wrapping 3 -> 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        arb_probe = ptr_q;
        for (int k = 0; k < 4; k++) begin
            arb_probe = ptr_q + 2'(k);
            if (!arb_found && Req[arb_probe]) begin
                arb_found = 1'b1;
                arb_idx   = arb_probe;
            end
        end
    end

    // Handshake: in DRIVE, Req[w] is the valid for Sym[w]; Ack[w] is its combinational
    // echo and marks that symbol consumed this cycle. Dropping Req[w] ends the grant.
    assign req_w      = Req[win_q];
    assign sym_w      = Sym[{win_q, 1'b0} +: 2];
    assign consume    = (state_q == ST_DRIVE) && req_w;
    assign burst_done = (cnt_q + 4'd1) == BURST_MAX;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_found) state_d = ST_CLR;
            ST_CLR:   state_d = ST_DRIVE;
            ST_DRIVE: if (!req_w || burst_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        win_d = win_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    win_d = arb_idx;
                    gnt_d = 4'b0001 << arb_idx;
                end
            end
            ST_CLR: cnt_d = '0;
            ST_DRIVE: begin
                if (consume) cnt_d = cnt_q + 4'd1;
                if (state_d == ST_IDLE) begin
                    gnt_d = '0;
                    ptr_d = win_q + 2'd1;
                end
            end
            default: gnt_d = '0;
        endcase
        core_rst_d = (state_d == ST_CLR);
    end

    always_comb begin
        Ack          = '0;
        Core_Data_In = IDLE_SYM;
        if (consume) begin
            Ack[win_q]   = 1'b1;
            Core_Data_In = sym_w;
        end
    end

    // The core answers one cycle after taking a symbol; capture that answer one cycle later.
    always_comb begin
        ack_dly_d    = consume;
        id_dly_d     = consume ? win_q : id_dly_q;
        resp_valid_d = ack_dly_q;
        resp_d       = ack_dly_q ? Core_Data_Out : resp_q;
        resp_id_d    = ack_dly_q ? id_dly_q : resp_id_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            win_q        <= '0;
            gnt_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            core_rst_q   <= 1'b1;
            ack_dly_q    <= 1'b0;
            id_dly_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            win_q        <= win_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            core_rst_q   <= core_rst_d;
            ack_dly_q    <= ack_dly_d;
            id_dly_q     <= id_dly_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign Gnt        = gnt_q;
    assign Busy       = (state_q == ST_CLR) || (state_q == ST_DRIVE);
    assign Core_Reset = core_rst_q;
    assign Resp_Valid = resp_valid_q;
    assign Resp       = resp_q;
    assign Resp_Id    = resp_id_q;
    assign dbg_state  = state_q;

    a_gnt_onehot: assert property (@(posedge Clock) disable iff (!Reset) $onehot0(gnt_q));
    a_ack_in_gnt: assert property (@(posedge Clock) disable iff (!Reset) (Ack & ~gnt_q) == 4'b0000);

endmodule

// File: tb/tb_fsm_core_scheduler.sv
// Bench for fsm_core_scheduler: two instances (burst caps 4 and 1) share random stimulus
// and are checked every cycle against a transaction-level model of the scheduling rules.
module tb_fsm_core_scheduler;

    localparam logic [1:0] IDLE_SYM = 2'b00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] sym;

    logic [3:0] gnt           [2];
    logic [3:0] ack           [2];
    logic       resp_valid    [2];
    logic       resp          [2];
    logic [1:0] resp_id       [2];
    logic       busy          [2];
    logic [1:0] core_data_in  [2];
    logic       core_reset    [2];
    logic       core_data_out [2];
    logic [1:0] dbg_state     [2];
    logic [1:0] core_st       [2];

    int n_cmp = 0;
    int n_err = 0;
    int bmax [2] = '{4, 1};
    int m_owner [2];
    int m_clr   [2];
    int m_cnt   [2];
    int m_ptr   [2];
    int m_sum   [2];
    int cyc = 0;
    logic [18:0] exp_q0 [$];
    logic [18:0] exp_q1 [$];
    logic [3:0]  resp_log;
    logic [2:0]  last_rsp;
    logic [3:0]  req_r;

    always #5 clk = ~clk;

    fsm_core_scheduler #(.BURST_MAX(4'd4), .IDLE_SYM(IDLE_SYM)) dut0 (
        .Clock(clk), .Reset(rst_n), .Req(req), .Sym(sym),
        .Gnt(gnt[0]), .Ack(ack[0]), .Resp_Valid(resp_valid[0]), .Resp(resp[0]),
        .Resp_Id(resp_id[0]), .Busy(busy[0]), .Core_Data_In(core_data_in[0]),
        .Core_Reset(core_reset[0]), .Core_Data_Out(core_data_out[0]), .dbg_state(dbg_state[0])
    );

    fsm_core_scheduler #(.BURST_MAX(4'd1), .IDLE_SYM(IDLE_SYM)) dut1 (
        .Clock(clk), .Reset(rst_n), .Req(req), .Sym(sym),
        .Gnt(gnt[1]), .Ack(ack[1]), .Resp_Valid(resp_valid[1]), .Resp(resp[1]),
        .Resp_Id(resp_id[1]), .Busy(busy[1]), .Core_Data_In(core_data_in[1]),
        .Core_Reset(core_reset[1]), .Core_Data_Out(core_data_out[1]), .dbg_state(dbg_state[1])
    );

    // Stand-in core: state accumulates the symbol value mod 4, output is high in states 0 and 1.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            core_st[d] <= core_reset[d] ? 2'd0 : core_st[d] + core_data_in[d];
    end
    assign core_data_out[0] = ~core_st[0][1];
    assign core_data_out[1] = ~core_st[1][1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_clr[d]   = 0;
            m_cnt[d]   = 0;
            m_ptr[d]   = 0;
            m_sum[d]   = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic check_outputs(input int d);
        int         o = m_owner[d];
        logic       req_o;
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        logic [1:0] e_cdi;
        logic [18:0] e;
        logic       e_valid;
        req_o = (o >= 0) ? req[o[1:0]] : 1'b0;
        e_gnt = (o >= 0) ? 4'(1 << o) : 4'h0;
        e_ack = (o >= 0 && m_clr[d] == 0 && req_o) ? e_gnt : 4'h0;
        e_cdi = (e_ack != 4'h0) ? sym[2*o +: 2] : IDLE_SYM;
        e_valid = 1'b0;
        e = '0;
        if (d == 0 && exp_q0.size() > 0 && int'(exp_q0[0][18:3]) == cyc) begin
            e = exp_q0.pop_front();
            e_valid = 1'b1;
        end
        if (d == 1 && exp_q1.size() > 0 && int'(exp_q1[0][18:3]) == cyc) begin
            e = exp_q1.pop_front();
            e_valid = 1'b1;
        end
        check_eq($sformatf("d%0d_gnt", d), gnt[d], e_gnt);
        check_eq($sformatf("d%0d_ack", d), ack[d], e_ack);
        check_eq($sformatf("d%0d_busy", d), busy[d], (o >= 0));
        check_eq($sformatf("d%0d_core_reset", d), core_reset[d], (m_clr[d] != 0));
        check_eq($sformatf("d%0d_core_data_in", d), core_data_in[d], e_cdi);
        check_eq($sformatf("d%0d_resp_valid", d), resp_valid[d], e_valid);
        if (e_valid) begin
            check_eq($sformatf("d%0d_resp", d), resp[d], e[0]);
            check_eq($sformatf("d%0d_resp_id", d), resp_id[d], e[2:1]);
        end
        if (d == 0 && resp_valid[0] === 1'b1) begin
            resp_log = {resp_log[2:0], resp[0]};
            last_rsp = {resp_id[0], resp[0]};
        end
    endtask

    task automatic model_advance(input int d);
        int         o = m_owner[d];
        logic       r;
        logic [1:0] s;
        logic [18:0] ent;
        if (o < 0) begin
            if (req != 4'h0) begin
                for (int k = 0; k < 4; k++)
                    if (m_owner[d] < 0 && req[(m_ptr[d] + k) % 4]) m_owner[d] = (m_ptr[d] + k) % 4;
                m_clr[d] = 1;
            end
        end else if (m_clr[d] != 0) begin
            m_clr[d] = 0;
            m_cnt[d] = 0;
            m_sum[d] = 0;
        end else begin
            if (req[o[1:0]]) begin
                s = sym[2*o +: 2];
                m_sum[d] = (m_sum[d] + int'(s)) % 4;
                r = (m_sum[d] < 2);
                ent = {16'(cyc + 2), o[1:0], r};
                if (d == 0) exp_q0.push_back(ent);
                else        exp_q1.push_back(ent);
                m_cnt[d]++;
            end
            if (!req[o[1:0]] || m_cnt[d] == bmax[d]) begin
                m_owner[d] = -1;
                m_ptr[d]   = (o + 1) % 4;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [7:0] s);
        @(negedge clk);
        req = r;
        sym = s;
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_advance(d);
        cyc++;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_rst_gnt", d), gnt[d], 4'h0);
            check_eq($sformatf("d%0d_rst_ack", d), ack[d], 4'h0);
            check_eq($sformatf("d%0d_rst_resp_valid", d), resp_valid[d], 1'b0);
            check_eq($sformatf("d%0d_rst_busy", d), busy[d], 1'b0);
            check_eq($sformatf("d%0d_rst_core_reset", d), core_reset[d], 1'b1);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        req   = 4'h0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'h0;
        sym      = 8'h00;
        req_r    = 4'h0;
        resp_log = 4'h0;
        last_rsp = 3'b000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_init_gnt", d), gnt[d], 4'h0);
            check_eq($sformatf("d%0d_init_ack", d), ack[d], 4'h0);
            check_eq($sformatf("d%0d_init_resp_valid", d), resp_valid[d], 1'b0);
            check_eq($sformatf("d%0d_init_resp", d), resp[d], 1'b0);
            check_eq($sformatf("d%0d_init_resp_id", d), resp_id[d], 2'd0);
            check_eq($sformatf("d%0d_init_busy", d), busy[d], 1'b0);
            check_eq($sformatf("d%0d_init_core_reset", d), core_reset[d], 1'b1);
            check_eq($sformatf("d%0d_init_core_data_in", d), core_data_in[d], IDLE_SYM);
        end
        rst_n = 1'b1;

        // Single burst: symbols 10, 10, 11, 01 give responses 0, 1, 0, 1.
        step(4'b0001, 8'h00);
        step(4'b0001, 8'h00);
        step(4'b0001, 8'h02);
        step(4'b0001, 8'h02);
        step(4'b0001, 8'h03);
        step(4'b0001, 8'h01);
        repeat (3) step(4'b0000, 8'h00);
        check_eq("single_burst_resp_seq", resp_log, 4'b0101);

        // Core reinit: requester 0 leaves the core in state 3, requester 1 then sends 00.
        step(4'b0001, 8'h00);
        step(4'b0001, 8'h00);
        step(4'b0001, 8'h02);
        step(4'b0001, 8'h02);
        step(4'b0001, 8'h03);
        step(4'b0000, 8'h00);
        step(4'b0010, 8'h00);
        step(4'b0010, 8'h00);
        step(4'b0010, 8'h00);
        repeat (3) step(4'b0000, 8'h00);
        check_eq("reinit_last_resp", last_rsp, {2'd1, 1'b1});

        // Reset in the second DRIVE cycle of a grant to requester 1.
        step(4'b0010, 8'h00);
        step(4'b0010, 8'h00);
        step(4'b0010, 8'h04);
        reset_mid();
        step(4'b1001, 8'h00);
        #2;
        check_eq("ptr_after_reset", gnt[0], 4'b0001);
        repeat (5) step(4'b0000, 8'h00);

        // Fairness with every requester held.
        repeat (24) step(4'b1111, 8'($urandom));
        repeat (3) step(4'b0000, 8'h00);

        // Burst cap with requester 2 held, then an early drop after one symbol.
        repeat (10) step(4'b0100, 8'($urandom));
        repeat (3) step(4'b0000, 8'h00);
        repeat (3) step(4'b0100, 8'($urandom));
        repeat (3) step(4'b0000, 8'h00);

        // Pipelined tail: requester 3 waits while requester 0 finishes.
        repeat (2) step(4'b0001, 8'($urandom));
        repeat (4) step(4'b1001, 8'($urandom));
        repeat (4) step(4'b1000, 8'($urandom));
        repeat (4) step(4'b0000, 8'h00);

        for (int i = 0; i < 1500; i++) begin
            req_r = req_r ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) reset_mid();
            else step(req_r, 8'($urandom));
        end
        repeat (4) step(4'b0000, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_core_scheduler.md
# fsm_core_scheduler

Round-robin scheduler that shares one 2-bit-input Moore FSM core between four requesters. Each grant first resets the core to ST0 with a one-cycle synchronous pulse, then streams the winner's 2-bit symbols into the core. It returns one registered response bit per symbol, tagged with the requester ID. It sits between the requester logic and the core's `Data_In`/`Reset`/`Data_Out` pins.

## Interface
- `BURST_MAX`, 8: maximum symbols per grant. Legal range 1..15; 4-bit counter.
- `IDLE_SYM`, 2'b00: symbol driven into the core when no grant is in the DRIVE state.

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset. 0 clears all state.
- `Req`  in  4  per-requester request. During the requester's grant it also qualifies `Sym`.
- `Sym`  in  8  per-requester symbol. Requester i drives `Sym[2i+1:2i]`.
- `Gnt`  out  4  one-hot grant, registered. High for the whole CLR and DRIVE period.
- `Ack`  out  4  one-hot. High in each cycle the granted symbol is consumed.
- `Resp_Valid`  out  1  registered response strobe.
- `Resp`  out  1  registered core output for the acknowledged symbol.
- `Resp_Id`  out  2  registered requester index of `Resp`.
- `Busy`  out  1  high when the state is CLR or DRIVE.
- `Core_Data_In`  out  2  drives the core's `Data_In`.
- `Core_Reset`  out  1  drives the core's active-high synchronous `Reset`.
- `Core_Data_Out`  in  1  the core's Moore output.

## Operation
- States: IDLE, CLR, DRIVE. State encoding 2 bits; the unused code returns to IDLE.
- Reset values: state IDLE, `Gnt`=0, `Ack`=0, `Resp_Valid`=0, `Resp`=0, `Resp_Id`=0, `Busy`=0, rr pointer=0, burst count=0, `Core_Reset`=1. The core is held in reset while the scheduler is in reset.
- `Core_Reset` is a registered output. It is 1 in CLR and during reset, else 0.

**IDLE**
- `Core_Data_In`=`IDLE_SYM`.
- If any `Req` is high, choose the winner w as the first requester at or after the rr pointer (cyclic 0→1→2→3→0).
- Register `Gnt[w]`=1 and go to CLR. Otherwise stay in IDLE.

**CLR** (exactly 1 cycle)
- `Core_Reset`=1 and `Core_Data_In`=`IDLE_SYM`. The core enters ST0 at the closing edge.
- Clear the burst count. Go to DRIVE.

**DRIVE**
- `Core_Data_In`=`Sym[w]` combinationally. `Ack[w]`=`Req[w]` combinationally.
- Each cycle with `Req[w]`=1 consumes one symbol and increments the count.
- The grant ends and the state returns to IDLE at the closing edge when either:
  - `Req[w]`=0: no symbol is consumed and `Core_Data_In`=`IDLE_SYM` that cycle; or
  - the consumed symbol makes count = `BURST_MAX`.
- When the grant ends: `Gnt` clears at that edge and the rr pointer becomes w+1 mod 4.

**Response path**
- An `Ack` in cycle t registers `ack_d`/`id_d` at edge t+1.
- At edge t+2, `Resp`=`Core_Data_Out` (sampled during cycle t+1), `Resp_Id`=`id_d`, `Resp_Valid`=1.
- This pipeline runs independently of the FSM, so the responses of a finished grant still emerge during the next IDLE/CLR cycles.
- Back-to-back grants keep their responses correct: the post-grant IDLE cycle drives `IDLE_SYM`, which affects the core only after the last response sample.

## Timing
- Request to grant: `Req` rising in cycle t while IDLE gives `Gnt` at t+1 (CLR) and the first `Ack` at t+2 at the earliest.
- Symbol to response: `Resp_Valid` exactly 2 cycles after the corresponding `Ack`. Responses keep symbol order; throughput is one per cycle.
- Overhead per grant: 2 cycles (IDLE arbitration + CLR). The minimum period between grants is `BURST_MAX`+2 cycles.
- Simultaneous requests: only the rr order decides; a new `Req` during another grant waits. Requests are not latched; a `Req` dropped before arbitration is lost.
- `Gnt` and `Ack` never have more than one bit set.
- Asynchronous reset mid-burst: all outputs go to their reset values immediately, and any in-flight responses are discarded. After release, the first action is IDLE then CLR, so no partial core state survives.
- `BURST_MAX`=1: DRIVE lasts one consuming cycle.

## Test plan
- **Single burst.** Req0, Sym0 = 10, 10, 11, 01 (`BURST_MAX`=8), then Req0 drops → `Ack0` ×4, `Resp` 0, 1, 0, 1 with `Resp_Id`=0, each 2 cycles after its `Ack`; return to IDLE.
- **Fairness.** `Req`=4'b1111 held, `BURST_MAX`=2 → grant order 0, 1, 2, 3, 0; each grant is 2 `Ack`s followed by 2 gap cycles.
- **Core reinit.** Req0 drives 10, 10, 11 (core left in ST3), then Req1 sends 00 → Req1's `Resp`=1, because CLR put the core in ST0 and 00 keeps it there.
- **Burst cap / early drop.** `BURST_MAX`=3 with Req2 held for 10 cycles → exactly 3 `Ack`s, then re-arbitration re-grants requester 2. Dropping Req2 after 1 symbol → 1 `Ack`, grant ends.
- **Reset mid-burst.** `Reset`=0 during the 2nd DRIVE cycle → `Gnt`=0, `Resp_Valid`=0, `Core_Reset`=1 immediately. After release, no stale response appears and the rr pointer is 0.
- **Pipelined tail.** Req0 burst ends with Req3 already pending → Req0's last 2 responses appear during Req3's IDLE/CLR cycles with `Resp_Id`=0, values unaffected.
